// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, memory size, sync marker and loader state encoding.
// The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;
    localparam int INSTRUCTION_LEN = 32;
    localparam int INSTRUCTION_MEM_SIZE = 1024;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_COUNT = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM  = 3'd5,
`endif
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_e;
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: shifts bytes MSB-first into a 32-bit word, flags the 4th byte.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       byte_valid_i,
    input  logic [7:0]                 byte_i,
    output logic [INSTRUCTION_LEN-1:0] word_o,
    output logic                       word_valid_o
);
    logic [INSTRUCTION_LEN-1:0] word_q;
    logic [1:0]                 cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (byte_valid_i) begin
            word_q <= {word_q[INSTRUCTION_LEN-9:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = byte_valid_i && cnt_q == 2'd3;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader driving the instruction memory write port.
// Define LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte per frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         MEM_BYTES = INSTRUCTION_MEM_SIZE,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [INSTRUCTION_LEN-1:0] mem_wdata,
    output logic                       mem_write,
    output logic                       cpu_hold,
    output logic                       done,
    output logic                       err,
    output logic [15:0]                words_written
);
`ifdef LOADER_CHECKSUM_EN
    localparam state_e FRAME_END = S_CSUM;
`else
    localparam state_e FRAME_END = S_DONE;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       count_q, words_q;
    logic [1:0]        hcnt_q;
    logic              err_q;
    logic              acc, sync_acc, word_valid, over;
    logic [15:0]       count_nx;
    logic [ADDR_W+1:0] end_addr;

    assign acc      = in_valid && in_ready;
    assign sync_acc = state_q == S_IDLE && acc && in_data == SYNC_BYTE;
    assign count_nx = {count_q[7:0], in_data};
    // Range end computed two bits wider than the address so it cannot wrap.
    assign end_addr = (ADDR_W+2)'(addr_q) + (ADDR_W+2)'({count_nx, 2'b00});
    assign over     = end_addr > (ADDR_W+2)'(MEM_BYTES);

    imem_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (sync_acc),
        .byte_valid_i (acc && state_q == S_DATA),
        .byte_i       (in_data),
        .word_o       (mem_wdata),
        .word_valid_o (word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_nx;
    assign sum_nx = sum_q + in_data;
    always_ff @(posedge clk) begin
        if (rst || sync_acc)
            sum_q <= '0;
        else if (acc && state_q != S_IDLE)
            sum_q <= sum_nx;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sync_acc) state_d = S_ADDR;
            S_ADDR:  if (acc && hcnt_q == 2'd3) state_d = S_COUNT;
            S_COUNT: if (acc && hcnt_q[0])
                         state_d = addr_q[1:0] != 2'd0 ? S_ERR :
                                   over                ? S_ERR :
                                   count_nx == 16'd0   ? FRAME_END : S_DATA;
            S_DATA:  if (word_valid) state_d = S_WRITE;
            S_WRITE: state_d = words_q + 16'd1 == count_q ? FRAME_END : S_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:  if (acc) state_d = sum_nx == 8'd0 ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            words_q <= '0;
            hcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (sync_acc) begin
                words_q <= '0;
                hcnt_q  <= '0;
                err_q   <= 1'b0;
            end
            if (acc && state_q == S_ADDR) begin
                addr_q <= {addr_q[ADDR_W-9:0], in_data};
                hcnt_q <= hcnt_q + 2'd1;
            end
            if (acc && state_q == S_COUNT) begin
                count_q <= count_nx;
                hcnt_q  <= hcnt_q + 2'd1;
            end
            if (state_q == S_WRITE) begin
                addr_q  <= addr_q + ADDR_W'(4);
                words_q <= words_q + 16'd1;
            end
            if (state_q == S_ERR)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        in_ready      = !rst && !(state_q inside {S_WRITE, S_DONE, S_ERR});
        mem_write     = !rst && state_q == S_WRITE;
        cpu_hold      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
        done          = state_q == S_DONE;
        err           = err_q || state_q == S_ERR;
        mem_addr      = addr_q;
        words_written = words_q;
    end
endmodule
